// File: rtl/opl3_seq_pkg.sv
// Shared types for the OPL3 write sequencer: FSM states, queued write entries
// and requester identifiers.
package opl3_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      IDX_WE,
      IDX_GAP,
      DAT_WE,
      DAT_GAP
   } seq_state_t;

   typedef struct packed {
      logic [8:0] regnum;
      logic [7:0] data;
   } seq_entry_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   function automatic int max3(input int x, input int y, input int z);
      int m;
      m = (x > y) ? x : y;
      return (m > z) ? m : z;
   endfunction

endpackage

// File: rtl/opl3_seq_fifo.sv
// Per-requester synchronous FIFO of register writes; pointers carry an extra
// wrap bit so full and empty are told apart without a separate counter.
module opl3_seq_fifo
   import opl3_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  seq_entry_t wdata,
   input  logic       pop,
   output seq_entry_t rdata,
   output logic       full,
   output logic       empty
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [IDX_W:0] wr_ptr;
   logic [IDX_W:0] rd_ptr;
   seq_entry_t     mem [DEPTH];
   logic           do_push;
   logic           do_pop;

   // A full FIFO refuses a push even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign empty = (wr_ptr == rd_ptr);
   assign rdata = mem[rd_ptr[IDX_W-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/opl3_write_sequencer.sv
// Paced, round-robin arbitrated write front-end for the OPL3 register port:
// each queued write becomes an index write then a data write with settle gaps.
module opl3_write_sequencer
   import opl3_seq_pkg::*;
#(
   parameter int WE_CYCLES  = 2,
   parameter int ADDR_GAP   = 4,
   parameter int DATA_GAP   = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [8:0] a_reg,
   input  logic [7:0] a_data,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [8:0] b_reg,
   input  logic [7:0] b_data,
   output logic [1:0] opl_addr,
   output logic [7:0] opl_din,
   output logic       opl_we,
   output logic       busy
);

   localparam int MAX_CNT = max3(WE_CYCLES, ADDR_GAP, DATA_GAP);
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   req_id_t          last_grant;
   seq_entry_t       hold;
   seq_entry_t       a_head;
   seq_entry_t       b_head;
   seq_entry_t       grant_entry;
   logic             a_full;
   logic             a_empty;
   logic             b_full;
   logic             b_empty;
   logic             grant_a;
   logic             grant_b;

   opl3_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk   (clk),
      .reset (reset),
      .push  (a_valid),
      .wdata ('{regnum: a_reg, data: a_data}),
      .pop   (grant_a),
      .rdata (a_head),
      .full  (a_full),
      .empty (a_empty)
   );

   opl3_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk   (clk),
      .reset (reset),
      .push  (b_valid),
      .wdata ('{regnum: b_reg, data: b_data}),
      .pop   (grant_b),
      .rdata (b_head),
      .full  (b_full),
      .empty (b_empty)
   );

   assign a_ready = !a_full;
   assign b_ready = !b_full;
   assign busy    = (state != IDLE) || !a_empty || !b_empty;

   // Arbitration only in IDLE, which keeps each index/data pair atomic.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == IDLE) begin
         if (!a_empty && !b_empty) begin
            if (last_grant == REQ_B) grant_a = 1'b1;
            else                     grant_b = 1'b1;
         end else if (!a_empty) begin
            grant_a = 1'b1;
         end else if (!b_empty) begin
            grant_b = 1'b1;
         end
      end
   end

   always_comb begin
      grant_entry = grant_a ? a_head : b_head;
   end

   always_ff @(posedge clk) begin
      if (grant_a || grant_b) hold <= grant_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= REQ_B;
         opl_we     <= 1'b0;
         opl_addr   <= 2'b00;
         opl_din    <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (grant_a || grant_b) begin
                  state      <= IDX_WE;
                  cnt        <= CNT_W'(WE_CYCLES - 1);
                  last_grant <= grant_a ? REQ_A : REQ_B;
                  opl_we     <= 1'b1;
                  opl_addr   <= {grant_entry.regnum[8], 1'b0};
                  opl_din    <= grant_entry.regnum[7:0];
               end
            end
            IDX_WE: begin
               if (cnt == '0) begin
                  state  <= IDX_GAP;
                  cnt    <= CNT_W'(ADDR_GAP - 1);
                  opl_we <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            IDX_GAP: begin
               if (cnt == '0) begin
                  state    <= DAT_WE;
                  cnt      <= CNT_W'(WE_CYCLES - 1);
                  opl_we   <= 1'b1;
                  opl_addr <= {hold.regnum[8], 1'b1};
                  opl_din  <= hold.data;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DAT_WE: begin
               if (cnt == '0) begin
                  state  <= DAT_GAP;
                  cnt    <= CNT_W'(DATA_GAP - 1);
                  opl_we <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DAT_GAP: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: begin
               state  <= IDLE;
               opl_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_opl3_write_sequencer.sv
// Scoreboard bench for opl3_write_sequencer: default-timing instance plus a
// minimum-gap instance (WE_CYCLES=ADDR_GAP=DATA_GAP=1).
module tb_opl3_write_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic [8:0] a_reg = '0, b_reg = '0;
   logic [7:0] a_data = '0, b_data = '0;
   logic       a_ready, b_ready;
   logic [1:0] opl_addr;
   logic [7:0] opl_din;
   logic       opl_we, busy;

   logic       fa_valid = 1'b0, fb_valid = 1'b0;
   logic [8:0] fa_reg = '0, fb_reg = '0;
   logic [7:0] fa_data = '0, fb_data = '0;
   logic       fa_ready, fb_ready;
   logic [1:0] f_addr;
   logic [7:0] f_din;
   logic       f_we, f_busy;

   opl3_write_sequencer dut (
      .clk(clk), .reset(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .opl_addr(opl_addr), .opl_din(opl_din), .opl_we(opl_we), .busy(busy)
   );

   opl3_write_sequencer #(.WE_CYCLES(1), .ADDR_GAP(1), .DATA_GAP(1), .FIFO_DEPTH(4)) dut_fast (
      .clk(clk), .reset(rst),
      .a_valid(fa_valid), .a_ready(fa_ready), .a_reg(fa_reg), .a_data(fa_data),
      .b_valid(fb_valid), .b_ready(fb_ready), .b_reg(fb_reg), .b_data(fb_data),
      .opl_addr(f_addr), .opl_din(f_din), .opl_we(f_we), .busy(f_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Expected writes as {opl_addr, opl_din}
   logic [9:0] expq[$];
   logic [9:0] fexpq[$];
   int         f_idx_q[$];

   logic we_q = 1'b0;
   int   hi_start = 0, lo_start = -1, idx_rise = 0, n_rises = 0;

   always @(negedge clk) begin
      if (opl_we && !we_q) begin
         n_rises++;
         if (expq.size() == 0) fail_now("unexpected_write");
         else chk("write_order", {opl_addr, opl_din}, expq.pop_front());
         if (opl_addr[0]) chk("idx_to_dat", cyc - idx_rise, 6);
         else idx_rise = cyc;
         if (lo_start >= 0) chk("min_low_gap", (cyc - lo_start) >= 4, 1);
         hi_start = cyc;
      end
      if (!opl_we && we_q) begin
         chk("we_width", cyc - hi_start, 2);
         lo_start = cyc;
      end
      we_q = opl_we;
   end

   logic f_we_q = 1'b0;
   int   f_hi_start = 0, f_idx_rise = 0;

   always @(negedge clk) begin
      if (f_we && !f_we_q) begin
         if (fexpq.size() == 0) fail_now("fast_unexpected_write");
         else chk("fast_write_order", {f_addr, f_din}, fexpq.pop_front());
         if (f_addr[0]) chk("fast_idx_to_dat", cyc - f_idx_rise, 2);
         else begin
            f_idx_rise = cyc;
            f_idx_q.push_back(cyc);
         end
         f_hi_start = cyc;
      end
      if (!f_we && f_we_q) chk("fast_we_width", cyc - f_hi_start, 1);
      f_we_q = f_we;
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input bit sel_b, input logic [8:0] r, input logic [7:0] d,
                       input bit ex, output int acc);
      int k;
      k = 0;
      if (sel_b) begin b_valid = 1'b1; b_reg = r; b_data = d; end
      else       begin a_valid = 1'b1; a_reg = r; a_data = d; end
      while (!(sel_b ? b_ready : a_ready) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!(sel_b ? b_ready : a_ready)) fail_now("push_timeout");
      if (ex) begin
         expq.push_back({r[8], 1'b0, r[7:0]});
         expq.push_back({r[8], 1'b1, d});
      end
      acc = cyc + 1;
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic push_ab(input logic [8:0] ra, input logic [7:0] da,
                          input logic [8:0] rb, input logic [7:0] db);
      a_valid = 1'b1; a_reg = ra; a_data = da;
      b_valid = 1'b1; b_reg = rb; b_data = db;
      chk("tie_a_ready", a_ready, 1);
      chk("tie_b_ready", b_ready, 1);
      expq.push_back({ra[8], 1'b0, ra[7:0]});
      expq.push_back({ra[8], 1'b1, da});
      expq.push_back({rb[8], 1'b0, rb[7:0]});
      expq.push_back({rb[8], 1'b1, db});
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic push_f(input logic [8:0] r, input logic [7:0] d);
      fa_valid = 1'b1; fa_reg = r; fa_data = d;
      chk("fast_ready", fa_ready, 1);
      fexpq.push_back({r[8], 1'b0, r[7:0]});
      fexpq.push_back({r[8], 1'b1, d});
      @(negedge clk);
      fa_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while ((busy || f_busy) && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (busy || f_busy) fail_now("idle_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   int acc, acc_b, r0;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_opl_we", opl_we, 0);
      chk("rst_opl_addr", opl_addr, 0);
      chk("rst_opl_din", opl_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ready", b_ready, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single write on A
      push(1'b0, 9'h0B0, 8'h31, 1'b1, acc);
      wait_idle(200);
      chk("busy_fall", cyc, acc + 33);
      chk("grant_latency", idx_rise, acc + 1);
      chk("single_drained", expq.size(), 0);

      // Bank select on B
      push(1'b1, 9'h105, 8'h01, 1'b1, acc);
      wait_idle(200);
      chk("bank_drained", expq.size(), 0);

      // Tie arbitration, A wins first
      push_ab(9'h020, 8'hA0, 9'h140, 8'hB0);
      push_ab(9'h021, 8'hA1, 9'h141, 8'hB1);
      wait_idle(400);
      chk("tie_drained", expq.size(), 0);

      // Backpressure on A while B's transaction occupies the sequencer
      push(1'b1, 9'h0A0, 8'h11, 1'b1, acc_b);
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            int k;
            k = 0;
            while (!a_ready && k < 200) begin
               @(negedge clk);
               k++;
            end
            chk("ready_rise_cyc", cyc, acc_b + 34);
            chk("ready_rise_on_pop", {opl_we, opl_addr, opl_din}, {1'b1, 2'b00, 8'hC0});
         end
         push(1'b0, 9'h0C0 + 9'(i), 8'h40 + 8'(i), 1'b1, acc);
         if (i == 3) chk("a_ready_full", a_ready, 0);
      end
      wait_idle(600);
      chk("bp_drained", expq.size(), 0);

      // Reset mid-DAT_GAP with three entries still queued
      push(1'b0, 9'h0D0, 8'h55, 1'b1, acc);
      for (int i = 1; i < 4; i++) push(1'b0, 9'h0D0 + 9'(i), 8'h55, 1'b0, r0);
      while (cyc < acc + 14) @(negedge clk);
      chk("pre_reset_drained", expq.size(), 0);
      chk("pre_reset_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("reset_we_async", opl_we, 0);
      chk("reset_busy_async", busy, 0);
      chk("reset_a_ready", a_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      r0 = n_rises;
      repeat (50) @(negedge clk);
      chk("post_reset_quiet", n_rises, r0);
      chk("post_reset_busy", busy, 0);

      // Minimum gaps on the fast instance
      push_f(9'h1B0, 8'h21);
      push_f(9'h0B1, 8'h22);
      push_f(9'h0B2, 8'h23);
      wait_idle(200);
      chk("fast_idx_count", f_idx_q.size(), 3);
      if (f_idx_q.size() == 3) begin
         chk("fast_period_1", f_idx_q[1] - f_idx_q[0], 5);
         chk("fast_period_2", f_idx_q[2] - f_idx_q[1], 5);
      end
      chk("fast_drained", fexpq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/opl3_write_sequencer.md
# opl3_write_sequencer

Paced, arbitrated write front-end for the OPL3 core's register port. Two independent requesters (e.g. the AdLib-compatible port and the Sound Blaster FM port) each submit complete register writes (9-bit register number plus data byte). Requests are buffered in per-requester FIFOs and arbitrated round-robin. Each granted request is sequenced as an index write followed by a data write on the core's addr/din/we port, with programmable settle gaps between them. Sits between the bus decode and the OPL3 core, in the CPU clock domain.

## Interface
- WE_CYCLES, 2: cycles opl_we is held high per port write; must be ≥1.
- ADDR_GAP, 4: idle cycles after the index write, before the data write; must be ≥1.
- DATA_GAP, 24: idle cycles after the data write, before the next transaction; must be ≥1.
- FIFO_DEPTH, 4: entries per requester FIFO; must be a power of 2 and ≥2.

- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- a_valid  in  1  requester A offers a write.
- a_ready  out  1  A FIFO not full.
- a_reg  in  9  A register number; bit 8 selects bank.
- a_data  in  8  A register data.
- b_valid, b_ready, b_reg, b_data: same as A, for requester B.
- opl_addr  out  2  to core addr: {bank, 0} for the index write, {bank, 1} for the data write.
- opl_din  out  8  to core din.
- opl_we  out  1  to core we. The core edge-detects this signal, so it must return low between writes.
- busy  out  1  high when the FSM is not IDLE or either FIFO is non-empty.

## Operation
- Push: a write is accepted on any cycle with x_valid && x_ready. The entry {reg, data} goes to FIFO x.
- x_ready = !full. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO are both performed; the count is unchanged.
- Arbitration happens in IDLE only:
  - If exactly one FIFO is non-empty, it is granted.
  - If both are non-empty, the requester other than last_grant is granted.
  - last_grant resets to B, so A wins the first tie.
- On grant: the head entry is popped into a holding register, last_grant is updated, and the FSM goes to IDX_WE.
- FSM states:
  - IDLE: opl_we = 0.
  - IDX_WE: opl_we = 1, opl_addr = {reg[8], 0}, opl_din = reg[7:0]. Lasts WE_CYCLES cycles, then IDX_GAP.
  - IDX_GAP: opl_we = 0. Lasts ADDR_GAP cycles, then DAT_WE.
  - DAT_WE: opl_we = 1, opl_addr = {reg[8], 1}, opl_din = data. Lasts WE_CYCLES cycles, then DAT_GAP.
  - DAT_GAP: opl_we = 0. Lasts DATA_GAP cycles, then IDLE.
- One shared down-counter, sized to fit max(WE_CYCLES, ADDR_GAP, DATA_GAP). It loads on each state entry; the state advances when the counter reaches 0.
- Transactions are atomic: an index/data pair is never interleaved with the other requester's writes.
- opl_addr and opl_din hold their last values in gap states and in IDLE.
- All outputs are registered.

## Timing
- Reset values:
  - opl_we = 0, opl_addr = 0, opl_din = 0, busy = 0.
  - a_ready = b_ready = 1. FIFOs empty, FSM in IDLE, last_grant = B.
- Latency: a push at cycle N into an empty, idle sequencer gives grant at N+1 and opl_we high at N+2.
- Per-transaction occupancy: 1 + 2·WE_CYCLES + ADDR_GAP + DATA_GAP cycles (33 with defaults). Back-to-back transactions repeat at that period.
- opl_we is low for at least min(ADDR_GAP, DATA_GAP+1) cycles between pulses.
- Reset asserted mid-transaction: opl_we drops asynchronously, FIFO contents are discarded, and the partial write is not completed.
- The FIFO pointers carry one extra wrap bit. Full means the index bits are equal and the wrap bits differ; empty means both are equal. Wrap-around is exercised at FIFO_DEPTH pushes.

## Structure
- Package opl3_seq_pkg holds:
  - seq_state_t enum: IDLE, IDX_WE, IDX_GAP, DAT_WE, DAT_GAP.
  - seq_entry_t struct: reg[8:0], data[7:0].
  - a requester-id typedef.
- Sub-module opl3_seq_fifo: parameterised synchronous FIFO of seq_entry_t with push/pop/full/empty, instantiated once per requester.
- Top level contains the arbiter, FSM, counter and output registers.

## Test plan
- Single write: A pushes reg 0x0B0, data 0x31, defaults → opl_we pulses twice, 2 cycles each. First pulse has addr=0, din=0xB0. Second pulse has addr=1, din=0x31 and starts 6 cycles after the first pulse starts. busy falls 33 cycles after the grant.
- Bank select: B pushes reg 0x105, data 0x01 → addr=2 with din=0x05, then addr=3 with din=0x01.
- Tie arbitration: A and B push on the same cycle, both repeatedly → output order A, B, A, B. No index/data interleave occurs.
- Backpressure: A pushes 6 entries back-to-back with FIFO_DEPTH=4 → a_ready drops after the fourth accept and rises the cycle after the first pop. All accepted entries emerge in order; the refused beats are retried by the source and also emerge.
- Reset mid-DAT_GAP with 3 entries queued → opl_we = 0 and busy = 0 immediately. After release there is no output activity until a new push.
- Gap parameters ADDR_GAP=1, DATA_GAP=1, WE_CYCLES=1 → the period is 5 cycles, and opl_we has a low cycle between every pulse.
